res_station_array: RTL and testbench
====================================

# res_station_array

Parametrised multi-entry reservation station for one functional unit of the Tomasulo core. It replaces the per-entry register bundle plus external control with a self-contained array that allocates entries on dispatch, snoops the CDB to wake pending operands, and selects one ready entry per cycle for issue to its functional unit. It sits between the dispatch/rename stage and an ALU/branch unit, with tags referring to ROB entries.

## Interface
- data_width, 16, operand width
- tag_width, 3, ROB tag width (Qj, Qk, dest)
- num_entries, 4, station depth (2..16)
- op_width, 4, opcode width (lc3b_opcode)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of all entries (mispredict recovery)
- disp_valid  in  1  dispatch request this cycle
- disp_ready  out  1  at least one free entry (registered state only)
- disp_op  in  op_width  opcode
- disp_Vj, disp_Vk  in  data_width  operand values
- disp_Qj, disp_Qk  in  tag_width  producer tags when operand not valid
- disp_Vj_valid, disp_Vk_valid  in  1  operand value valid
- disp_dest  in  tag_width  destination ROB tag
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  tag_width  broadcast tag
- cdb_data  in  data_width  broadcast value
- iss_valid  out  1  a ready entry is presented
- iss_ready  in  1  functional unit accepts
- iss_op  out  op_width; iss_Vj, iss_Vk  out  data_width; iss_dest  out  tag_width  selected entry contents
- num_busy  out  clog2(num_entries)+1  occupied entry count

## Operation
- Entry state: busy, op, Vj, Vj_valid, Qj, Vk, Vk_valid, Qk, dest, age counter.
- Dispatch: when disp_valid && disp_ready, write lowest-index non-busy entry; set busy. disp_valid with disp_ready low is ignored (no write, no error).
- Dispatch bypass: if cdb_valid and cdb_tag equals disp_Qj with disp_Vj_valid=0, entry stores Vj=cdb_data, Vj_valid=1; same independently for Vk.
- Wakeup: each busy entry with Vx_valid=0 and Qx==cdb_tag on cdb_valid captures Vx=cdb_data, Vx_valid=1. Both operands may wake in the same cycle.
- Ready = busy && Vj_valid && Vk_valid (registered bits only; a CDB hit does not make an entry ready in the same cycle).
- Select: oldest ready entry (largest age); ties impossible by construction. Age: on dispatch entry age=0, all other busy entries increment, saturating at num_entries-1.
- Issue: iss_* combinationally driven from selected entry; iss_valid = any ready. On iss_valid && iss_ready entry busy clears at the edge. Outputs held stable while iss_valid && !iss_ready unless an older entry becomes ready.
- Freed entry is not reallocatable in the same cycle (disp_ready uses registered busy).
- flush: clears every busy bit and valid bit at the edge; overrides same-cycle dispatch, wakeup and issue. Other fields don't-care.
- rst: same effect as flush, asynchronously.

## Timing
- Reset/flush values: all busy=0, disp_ready=1, iss_valid=0, num_busy=0, iss_op/iss_Vj/iss_Vk/iss_dest=0.
- Dispatch at edge N with both operands valid (or bypassed) -> iss_valid earliest cycle N+1.
- CDB broadcast in cycle N waking last operand -> iss_valid cycle N+1.
- Issue accepted in cycle N -> entry free from N+1; disp_ready reflects it in N+1.
- Full (num_busy==num_entries): disp_ready=0; simultaneous issue does not raise it until next cycle.
- Simultaneous dispatch + issue: num_busy unchanged.
- CDB tag matching an entry whose operand already valid: no change.

## Test plan
- Reset then dispatch op=ADD, Vj=0x0003, Vk=0x0004 both valid -> next cycle iss_valid=1, iss_Vj=3, iss_Vk=4; iss_ready=1 -> num_busy 1->0.
- Dispatch Qj=2 (Vj invalid), Vk=5 valid; CDB tag 2 data 0x00AA two cycles later -> iss_valid asserts one cycle after broadcast with iss_Vj=0x00AA.
- Dispatch with Qj=Qk=6 same cycle as CDB tag 6 data 0x1234 -> bypass, iss_valid next cycle, both operands 0x1234.
- Fill 4 entries (num_busy=4, disp_ready=0), disp_valid held -> no overwrite; issue one -> disp_ready=1 next cycle, lowest freed index reused.
- Entries A (older) and B both become ready same cycle -> A issued first; iss_ready=0 for 3 cycles keeps A presented stably.
- flush with 3 busy entries and simultaneous dispatch/CDB -> next cycle num_busy=0, iss_valid=0; rst mid-cycle clears immediately without clock.

Source files
------------

// File: rtl/res_station_array.sv
// Multi-entry reservation station: allocates on dispatch, wakes operands
// from the CDB and issues the oldest ready entry to its functional unit.
module res_station_array #(
  parameter int data_width  = 16,
  parameter int tag_width   = 3,
  parameter int num_entries = 4,
  parameter int op_width    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          disp_valid_i,
  output logic                          disp_ready_o,
  input  logic [op_width-1:0]           disp_op_i,
  input  logic [data_width-1:0]         disp_Vj_i,
  input  logic [data_width-1:0]         disp_Vk_i,
  input  logic [tag_width-1:0]          disp_Qj_i,
  input  logic [tag_width-1:0]          disp_Qk_i,
  input  logic                          disp_Vj_valid_i,
  input  logic                          disp_Vk_valid_i,
  input  logic [tag_width-1:0]          disp_dest_i,
  input  logic                          cdb_valid_i,
  input  logic [tag_width-1:0]          cdb_tag_i,
  input  logic [data_width-1:0]         cdb_data_i,
  output logic                          iss_valid_o,
  input  logic                          iss_ready_i,
  output logic [op_width-1:0]           iss_op_o,
  output logic [data_width-1:0]         iss_Vj_o,
  output logic [data_width-1:0]         iss_Vk_o,
  output logic [tag_width-1:0]          iss_dest_o,
  output logic [$clog2(num_entries):0]  num_busy_o
);

  localparam int IW = $clog2(num_entries);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] AMAX = IW'(num_entries - 1);

  typedef logic [IW-1:0] idx_t;

  logic [num_entries-1:0]                 busy_q, busy_d;
  logic [num_entries-1:0]                 vjv_q, vjv_d;
  logic [num_entries-1:0]                 vkv_q, vkv_d;
  logic [num_entries-1:0][op_width-1:0]   op_q, op_d;
  logic [num_entries-1:0][data_width-1:0] vj_q, vj_d;
  logic [num_entries-1:0][data_width-1:0] vk_q, vk_d;
  logic [num_entries-1:0][tag_width-1:0]  qj_q, qj_d;
  logic [num_entries-1:0][tag_width-1:0]  qk_q, qk_d;
  logic [num_entries-1:0][tag_width-1:0]  dest_q, dest_d;
  logic [num_entries-1:0][IW-1:0]         age_q, age_d;

  logic [num_entries-1:0] rdy;
  logic                   iss_any;
  idx_t                   sel;
  idx_t                   alloc;
  logic [CW-1:0]          cnt;
  logic                   disp_fire;
  logic                   iss_fire;
  logic                   byp_j, byp_k;

  assign rdy = busy_q & vjv_q & vkv_q;

  always_comb begin
    iss_any = 1'b0;
    sel     = '0;
    for (int i = 0; i < num_entries; i++) begin
      if (rdy[i] && (!iss_any || age_q[i] > age_q[sel])) begin
        iss_any = 1'b1;
        sel     = idx_t'(i);
      end
    end
  end

  always_comb begin
    alloc = '0;
    for (int i = num_entries - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc = idx_t'(i);
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < num_entries; i++) begin
      cnt = cnt + CW'(busy_q[i]);
    end
  end

  assign disp_ready_o = ~&busy_q;
  assign num_busy_o   = cnt;
  assign disp_fire    = disp_valid_i & disp_ready_o;
  assign iss_fire     = iss_any & iss_ready_i;
  assign iss_valid_o  = iss_any;
  assign iss_op_o     = iss_any ? op_q[sel]   : '0;
  assign iss_Vj_o     = iss_any ? vj_q[sel]   : '0;
  assign iss_Vk_o     = iss_any ? vk_q[sel]   : '0;
  assign iss_dest_o   = iss_any ? dest_q[sel] : '0;

  assign byp_j = cdb_valid_i & ~disp_Vj_valid_i & (disp_Qj_i == cdb_tag_i);
  assign byp_k = cdb_valid_i & ~disp_Vk_valid_i & (disp_Qk_i == cdb_tag_i);

  always_comb begin
    busy_d = busy_q;
    vjv_d  = vjv_q;
    vkv_d  = vkv_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    dest_d = dest_q;
    age_d  = age_q;
    for (int i = 0; i < num_entries; i++) begin
      if (busy_q[i]) begin
        if (cdb_valid_i && !vjv_q[i] && qj_q[i] == cdb_tag_i) begin
          vj_d[i]  = cdb_data_i;
          vjv_d[i] = 1'b1;
        end
        if (cdb_valid_i && !vkv_q[i] && qk_q[i] == cdb_tag_i) begin
          vk_d[i]  = cdb_data_i;
          vkv_d[i] = 1'b1;
        end
        // Ages stay a dense rank of busy entries, so they never collide.
        if (!(iss_fire && sel == idx_t'(i))) begin
          if (disp_fire && !(iss_fire && age_q[i] > age_q[sel])) begin
            if (age_q[i] != AMAX) age_d[i] = age_q[i] + 1'b1;
          end else if (!disp_fire && iss_fire && age_q[i] > age_q[sel]) begin
            age_d[i] = age_q[i] - 1'b1;
          end
        end
      end
      if (iss_fire && sel == idx_t'(i)) begin
        busy_d[i] = 1'b0;
        vjv_d[i]  = 1'b0;
        vkv_d[i]  = 1'b0;
      end
      if (disp_fire && alloc == idx_t'(i)) begin
        busy_d[i] = 1'b1;
        op_d[i]   = disp_op_i;
        vj_d[i]   = disp_Vj_valid_i ? disp_Vj_i : cdb_data_i;
        vk_d[i]   = disp_Vk_valid_i ? disp_Vk_i : cdb_data_i;
        vjv_d[i]  = disp_Vj_valid_i | byp_j;
        vkv_d[i]  = disp_Vk_valid_i | byp_k;
        qj_d[i]   = disp_Qj_i;
        qk_d[i]   = disp_Qk_i;
        dest_d[i] = disp_dest_i;
        age_d[i]  = '0;
      end
    end
    if (flush_i) begin
      busy_d = '0;
      vjv_d  = '0;
      vkv_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      vjv_q  <= '0;
      vkv_q  <= '0;
      op_q   <= '0;
      vj_q   <= '0;
      vk_q   <= '0;
      qj_q   <= '0;
      qk_q   <= '0;
      dest_q <= '0;
      age_q  <= '0;
    end else begin
      busy_q <= busy_d;
      vjv_q  <= vjv_d;
      vkv_q  <= vkv_d;
      op_q   <= op_d;
      vj_q   <= vj_d;
      vk_q   <= vk_d;
      qj_q   <= qj_d;
      qk_q   <= qk_d;
      dest_q <= dest_d;
      age_q  <= age_d;
    end
  end

endmodule

// File: tb/tb_res_station_array.sv
// Scoreboard bench for res_station_array: expected issues are queued at
// dispatch and checked by a negedge monitor on each accepted issue.
module tb_res_station_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_op;
  logic [15:0] disp_Vj, disp_Vk;
  logic [2:0]  disp_Qj, disp_Qk;
  logic        disp_Vj_valid, disp_Vk_valid;
  logic [2:0]  disp_dest;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [3:0]  iss_op;
  logic [15:0] iss_Vj, iss_Vk;
  logic [2:0]  iss_dest;
  logic [2:0]  num_busy;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [2:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  res_station_array dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush),
    .disp_valid_i    (disp_valid),
    .disp_ready_o    (disp_ready),
    .disp_op_i       (disp_op),
    .disp_Vj_i       (disp_Vj),
    .disp_Vk_i       (disp_Vk),
    .disp_Qj_i       (disp_Qj),
    .disp_Qk_i       (disp_Qk),
    .disp_Vj_valid_i (disp_Vj_valid),
    .disp_Vk_valid_i (disp_Vk_valid),
    .disp_dest_i     (disp_dest),
    .cdb_valid_i     (cdb_valid),
    .cdb_tag_i       (cdb_tag),
    .cdb_data_i      (cdb_data),
    .iss_valid_o     (iss_valid),
    .iss_ready_i     (iss_ready),
    .iss_op_o        (iss_op),
    .iss_Vj_o        (iss_Vj),
    .iss_Vk_o        (iss_Vk),
    .iss_dest_o      (iss_dest),
    .num_busy_o      (num_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got op=%h vj=%h vk=%h dest=%h",
                 iss_op, iss_Vj, iss_Vk, iss_dest);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({iss_op, iss_Vj, iss_Vk, iss_dest} !== e) begin
          n_err++;
          $display("FAIL issue_data: got op=%h vj=%h vk=%h dest=%h exp op=%h vj=%h vk=%h dest=%h",
                   iss_op, iss_Vj, iss_Vk, iss_dest, e.op, e.vj, e.vk, e.dest);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [15:0] vj,
                      input logic vjv, input logic [2:0] qj,
                      input logic [15:0] vk, input logic vkv,
                      input logic [2:0] qk, input logic [2:0] dest);
    disp_valid    = 1'b1;
    disp_op       = op;
    disp_Vj       = vj;
    disp_Vj_valid = vjv;
    disp_Qj       = qj;
    disp_Vk       = vk;
    disp_Vk_valid = vkv;
    disp_Qk       = qk;
    disp_dest     = dest;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    iss_ready = 1'b0;
    disp(4'h0, 16'h0, 1'b0, 3'h0, 16'h0, 1'b0, 3'h0, 3'h0);
    disp_valid = 1'b0;
    cdb_tag  = 3'h0;
    cdb_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_num_busy", 32'(num_busy), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_iss_fields", {iss_op, iss_Vj, iss_Vk, iss_dest}, 32'd0);
    chk("rst_iss_vk", 32'(iss_Vk), 32'd0);

    // basic ADD
    disp(4'h1, 16'h0003, 1'b1, 3'h0, 16'h0004, 1'b1, 3'h0, 3'h1);
    sb.push_back({4'h1, 16'h0003, 16'h0004, 3'h1});
    cyc(); clr();
    chk("add_iss_valid", 32'(iss_valid), 32'd1);
    chk("add_iss_vj", 32'(iss_Vj), 32'h3);
    chk("add_iss_vk", 32'(iss_Vk), 32'h4);
    chk("add_num_busy", 32'(num_busy), 32'd1);
    iss_ready = 1'b1;
    cyc(); iss_ready = 1'b0;
    chk("add_after_num_busy", 32'(num_busy), 32'd0);
    chk("add_after_valid", 32'(iss_valid), 32'd0);

    // CDB wakeup
    disp(4'h2, 16'h0, 1'b0, 3'h2, 16'h0005, 1'b1, 3'h0, 3'h2);
    sb.push_back({4'h2, 16'h00AA, 16'h0005, 3'h2});
    cyc(); clr();
    chk("wake_wait0", 32'(iss_valid), 32'd0);
    cyc();
    cdb(3'h2, 16'h00AA);
    chk("wake_wait1", 32'(iss_valid), 32'd0);
    cyc(); clr();
    chk("wake_valid", 32'(iss_valid), 32'd1);
    chk("wake_vj", 32'(iss_Vj), 32'h00AA);
    iss_ready = 1'b1;
    cyc(); iss_ready = 1'b0;
    chk("wake_num_busy", 32'(num_busy), 32'd0);

    // dispatch bypass on both operands
    disp(4'h3, 16'h0, 1'b0, 3'h6, 16'h0, 1'b0, 3'h6, 3'h3);
    cdb(3'h6, 16'h1234);
    sb.push_back({4'h3, 16'h1234, 16'h1234, 3'h3});
    cyc(); clr();
    chk("byp_valid", 32'(iss_valid), 32'd1);
    chk("byp_vk", 32'(iss_Vk), 32'h1234);
    iss_ready = 1'b1;
    cyc(); iss_ready = 1'b0;

    // fill, overflow attempt, free one and reuse
    for (int k = 0; k < 4; k++) begin
      disp(4'(4 + k), 16'(16'h10 + k), 1'b1, 3'h0,
           16'(16'h20 + k), 1'b1, 3'h0, 3'(k));
      sb.push_back({4'(4 + k), 16'(16'h10 + k), 16'(16'h20 + k), 3'(k)});
      cyc();
    end
    chk("full_num_busy", 32'(num_busy), 32'd4);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    disp(4'h8, 16'hDEAD, 1'b1, 3'h0, 16'hBEEF, 1'b1, 3'h0, 3'h7);
    cyc();
    chk("full_no_overwrite", 32'(num_busy), 32'd4);
    chk("full_oldest_op", 32'(iss_op), 32'h4);
    iss_ready = 1'b1;
    cyc(); iss_ready = 1'b0;
    disp(4'h9, 16'h0099, 1'b1, 3'h0, 16'h0098, 1'b1, 3'h0, 3'h5);
    sb.push_back({4'h9, 16'h0099, 16'h0098, 3'h5});
    chk("freed_disp_ready", 32'(disp_ready), 32'd1);
    chk("freed_num_busy", 32'(num_busy), 32'd3);
    cyc(); clr();
    chk("reuse_num_busy", 32'(num_busy), 32'd4);
    chk("reuse_index0", 32'(dut.op_q[0]), 32'h9);
    iss_ready = 1'b1;
    repeat (4) cyc();
    iss_ready = 1'b0;
    chk("drain_num_busy", 32'(num_busy), 32'd0);

    // age ordering and stable hold
    disp(4'hA, 16'h0, 1'b0, 3'h1, 16'h000A, 1'b1, 3'h0, 3'h5);
    sb.push_back({4'hA, 16'h0055, 16'h000A, 3'h5});
    cyc();
    disp(4'hB, 16'h0, 1'b0, 3'h1, 16'h000B, 1'b1, 3'h0, 3'h6);
    sb.push_back({4'hB, 16'h0055, 16'h000B, 3'h6});
    cyc(); clr();
    cdb(3'h1, 16'h0055);
    cyc(); clr();
    for (int k = 0; k < 3; k++) begin
      chk("hold_op", {iss_valid, 3'h0, iss_op, iss_Vk, 1'b0, iss_dest},
          {1'b1, 3'h0, 4'hA, 16'h000A, 1'b0, 3'h5});
      cyc();
    end
    iss_ready = 1'b1;
    cyc();
    chk("second_op", 32'(iss_op), 32'hB);
    cyc(); iss_ready = 1'b0;
    chk("age_num_busy", 32'(num_busy), 32'd0);

    // flush overrides dispatch and wakeup
    for (int k = 0; k < 3; k++) begin
      disp(4'(k), 16'h0, 1'b0, 3'h7, 16'h0, 1'b0, 3'h7, 3'(k));
      cyc();
    end
    clr();
    chk("pre_flush_busy", 32'(num_busy), 32'd3);
    flush = 1'b1;
    disp(4'hC, 16'h1, 1'b1, 3'h0, 16'h2, 1'b1, 3'h0, 3'h4);
    cdb(3'h7, 16'h7777);
    cyc(); clr();
    chk("flush_num_busy", 32'(num_busy), 32'd0);
    chk("flush_iss_valid", 32'(iss_valid), 32'd0);
    chk("flush_disp_ready", 32'(disp_ready), 32'd1);
    cyc();
    chk("flush_stays_idle", 32'(iss_valid), 32'd0);

    // asynchronous reset mid-cycle
    disp(4'hD, 16'h1, 1'b1, 3'h0, 16'h2, 1'b1, 3'h0, 3'h1);
    cyc();
    disp(4'hE, 16'h3, 1'b1, 3'h0, 16'h4, 1'b1, 3'h0, 3'h2);
    cyc(); clr();
    chk("pre_rst_busy", 32'(num_busy), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(num_busy), 32'd0);
    chk("async_rst_valid", 32'(iss_valid), 32'd0);
    #3 rst = 1'b0;
    cyc();
    chk("post_rst_busy", 32'(num_busy), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
